can_errcnt_gen: RTL and testbench



---
 rtl/can_fc_pkg.sv | 29 ++
 rtl/can_req_edge.sv | 33 +++
 rtl/can_errcnt_gen.sv | 132 +++++++++++++
 tb/tb_can_errcnt_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/can_fc_pkg.sv
// Shared fault-confinement definitions for the CAN error counters (REC/TEC).
package can_fc_pkg;

  localparam int MODE_REC = 0;
  localparam int MODE_TEC = 1;

  localparam int DEF_INC_BIG     = 8;
  localparam int DEF_WARN_TH     = 96;
  localparam int DEF_PASSIVE_TH  = 128;
  localparam int DEF_BUSOFF_TH   = 256;
  localparam int DEF_REC_RESTORE = 119;
  localparam int DEF_RECOV_SEQ   = 128;

  typedef enum logic {
    FC_ACTIVE = 1'b0,
    FC_BUSOFF = 1'b1
  } fc_state_e;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/can_req_edge.sv
// Request deglitch: a level request is accepted once, then must drop for a
// cycle before another acceptance is possible.
module can_req_edge #(
  parameter int N_REQ = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [N_REQ-1:0] req_i,
  output logic             accept_o
);
  import can_fc_pkg::*;

  logic act;
  logic armed_q;
  logic armed_d;

  assign act      = |req_i;
  assign accept_o = act & armed_q;
  // Any active cycle disarms; only an idle cycle re-arms.
  assign armed_d  = ~act;

  always_ff @(posedge clock) begin
    if (!reset) begin
      armed_q <= 1'b1;
    end else if (clear) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/can_errcnt_gen.sv
// CAN fault-confinement error counter; REC (MODE=0) or TEC (MODE=1) with
// threshold status and, for TEC, bus-off recovery on 11-recessive-bit pulses.
module can_errcnt_gen
  import can_fc_pkg::*;
#(
  parameter int CNT_W       = 9,
  parameter int MODE        = MODE_REC,
  parameter int INC_BIG     = DEF_INC_BIG,
  parameter int WARN_TH     = DEF_WARN_TH,
  parameter int PASSIVE_TH  = DEF_PASSIVE_TH,
  parameter int BUSOFF_TH   = DEF_BUSOFF_TH,
  parameter int REC_RESTORE = DEF_REC_RESTORE,
  parameter int RECOV_SEQ   = DEF_RECOV_SEQ,
  localparam int RW         = clog2(RECOV_SEQ + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_one,
  input  logic             inc_big,
  input  logic             dec_one,
  input  logic             rec11,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       count8,
  output logic             lt_warn,
  output logic             ge_warn,
  output logic             ge_passive,
  output logic             busoff,
  output logic             recov_done,
  output fc_state_e        dbg_state,
  output logic [RW-1:0]    dbg_recov_cnt
);

  localparam logic [CNT_W-1:0] WARN_C     = CNT_W'(WARN_TH);
  localparam logic [CNT_W-1:0] PASSIVE_C  = CNT_W'(PASSIVE_TH);
  localparam logic [CNT_W-1:0] BUSOFF_C   = CNT_W'(BUSOFF_TH);
  localparam logic [CNT_W-1:0] RESTORE_C  = CNT_W'(REC_RESTORE);
  localparam logic [CNT_W-1:0] BIG_C      = CNT_W'(INC_BIG);
  localparam logic [CNT_W-1:0] LEGACY_MAX = CNT_W'(255);
  localparam logic [RW-1:0]    RECOV_LAST = RW'(RECOV_SEQ - 1);

  if (!(WARN_TH < PASSIVE_TH)) begin : g_chk_warn
    $error("can_errcnt_gen: WARN_TH must be below PASSIVE_TH");
  end
  if (MODE == MODE_TEC && BUSOFF_TH > (2 ** CNT_W) - 1) begin : g_chk_busoff
    $error("can_errcnt_gen: BUSOFF_TH does not fit in CNT_W");
  end
  if (!(REC_RESTORE < PASSIVE_TH)) begin : g_chk_restore
    $error("can_errcnt_gen: REC_RESTORE must be below PASSIVE_TH");
  end

  fc_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RW-1:0]    recov_q, recov_d;
  logic             done_q, done_d;
  logic             accept;
  logic [CNT_W-1:0] step;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] inc_val;
  logic             inc_hold;

  can_req_edge #(.N_REQ(3)) u_req_edge (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .req_i    ({inc_one, inc_big, dec_one}),
    .accept_o (accept)
  );

  assign step     = inc_one ? CNT_W'(1) : BIG_C;
  assign sum      = {1'b0, count_q} + {1'b0, step};
  assign inc_val  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  // REC keeps the 9-bit legacy behaviour: no further increments above 255.
  assign inc_hold = (MODE == MODE_REC) && (count_q > LEGACY_MAX);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    recov_d = recov_q;
    done_d  = 1'b0;
    if (state_q == FC_ACTIVE) begin
      if (accept) begin
        if (dec_one) begin
          // A decrement at zero still consumes the request.
          if (count_q != '0) begin
            if (MODE == MODE_REC && count_q >= PASSIVE_C) count_d = RESTORE_C;
            else                                           count_d = count_q - 1'b1;
          end
        end else if (!inc_hold) begin
          count_d = inc_val;
          if (MODE == MODE_TEC && inc_val >= BUSOFF_C) state_d = FC_BUSOFF;
        end
      end
    end else begin
      if (rec11) begin
        if (recov_q == RECOV_LAST) begin
          count_d = '0;
          recov_d = '0;
          state_d = FC_ACTIVE;
          done_d  = 1'b1;
        end else begin
          recov_d = recov_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      state_q <= FC_ACTIVE;
      count_q <= '0;
      recov_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      recov_q <= recov_d;
      done_q  <= done_d;
    end
  end

  assign busoff        = (state_q == FC_BUSOFF);
  assign count         = count_q;
  assign count8        = (count_q > LEGACY_MAX) ? 8'hFF : count_q[7:0];
  assign ge_warn       = busoff | (count_q >= WARN_C);
  assign lt_warn       = ~ge_warn;
  assign ge_passive    = busoff | (count_q >= PASSIVE_C);
  assign recov_done    = done_q;
  assign dbg_state     = state_q;
  assign dbg_recov_cnt = recov_q;

endmodule

// File: tb/tb_can_errcnt_gen.sv
// Directed bench for can_errcnt_gen: one REC and one TEC instance on shared stimulus.
module tb_can_errcnt_gen;
  import can_fc_pkg::*;

  logic clock;
  logic reset;
  logic clear;
  logic inc_one;
  logic inc_big;
  logic dec_one;
  logic rec11;

  logic [8:0] r_count, t_count;
  logic [7:0] r_count8, t_count8;
  logic       r_lt, r_ge, r_pas, r_bo, r_done;
  logic       t_lt, t_ge, t_pas, t_bo, t_done;
  fc_state_e  r_st, t_st;
  logic [7:0] r_rc, t_rc;

  int n_cmp;
  int n_fail;

  can_errcnt_gen #(.MODE(MODE_REC)) u_rec (
    .clock(clock), .reset(reset), .clear(clear),
    .inc_one(inc_one), .inc_big(inc_big), .dec_one(dec_one), .rec11(rec11),
    .count(r_count), .count8(r_count8), .lt_warn(r_lt), .ge_warn(r_ge),
    .ge_passive(r_pas), .busoff(r_bo), .recov_done(r_done),
    .dbg_state(r_st), .dbg_recov_cnt(r_rc)
  );

  can_errcnt_gen #(.MODE(MODE_TEC)) u_tec (
    .clock(clock), .reset(reset), .clear(clear),
    .inc_one(inc_one), .inc_big(inc_big), .dec_one(dec_one), .rec11(rec11),
    .count(t_count), .count8(t_count8), .lt_warn(t_lt), .ge_warn(t_ge),
    .ge_passive(t_pas), .busoff(t_bo), .recov_done(t_done),
    .dbg_state(t_st), .dbg_recov_cnt(t_rc)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Drivers: hold a request pattern for 'hold' cycles, then one idle cycle.
  task automatic req(input logic io, input logic ib, input logic dd, input int hold);
    inc_one = io; inc_big = ib; dec_one = dd;
    repeat (hold) @(negedge clock);
    inc_one = 1'b0; inc_big = 1'b0; dec_one = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_rec11(input int n);
    for (int i = 0; i < n; i++) begin
      rec11 = 1'b1;
      @(negedge clock);
      rec11 = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (r_count !== 9'd0) begin n_fail++; $display("FAIL rst_rec_count got %0d want 0", r_count); end
    n_cmp++; if (t_count !== 9'd0) begin n_fail++; $display("FAIL rst_tec_count got %0d want 0", t_count); end
    n_cmp++; if ({r_lt, r_ge, r_pas, r_bo, r_done} !== 5'b10000) begin n_fail++; $display("FAIL rst_rec_status got %b want 10000", {r_lt, r_ge, r_pas, r_bo, r_done}); end
    n_cmp++; if ({t_lt, t_ge, t_pas, t_bo, t_done} !== 5'b10000) begin n_fail++; $display("FAIL rst_tec_status got %b want 10000", {t_lt, t_ge, t_pas, t_bo, t_done}); end
    n_cmp++; if (t_rc !== 8'd0) begin n_fail++; $display("FAIL rst_tec_recov got %0d want 0", t_rc); end
  endtask

  task automatic test_rec_warn();
    do_reset();
    req(1'b1, 1'b0, 1'b0, 5);
    n_cmp++; if (r_count !== 9'd1) begin n_fail++; $display("FAIL held_burst_one got %0d want 1", r_count); end
    for (int i = 1; i < 96; i++) req(1'b1, 1'b0, 1'b0, 5);
    n_cmp++; if (r_count !== 9'd96) begin n_fail++; $display("FAIL warn_count got %0d want 96", r_count); end
    n_cmp++; if ({r_lt, r_ge, r_pas} !== 3'b010) begin n_fail++; $display("FAIL warn_status got %b want 010", {r_lt, r_ge, r_pas}); end
    n_cmp++; if (r_count8 !== 8'd96) begin n_fail++; $display("FAIL warn_count8 got %0d want 96", r_count8); end
  endtask

  task automatic test_rec_restore();
    do_reset();
    for (int i = 0; i < 16; i++) req(1'b0, 1'b1, 1'b0, 1);
    n_cmp++; if ({r_count, r_pas} !== {9'd128, 1'b1}) begin n_fail++; $display("FAIL passive_128 got %0d/%b want 128/1", r_count, r_pas); end
    req(1'b1, 1'b0, 1'b0, 1);
    req(1'b1, 1'b0, 1'b0, 1);
    req(1'b0, 1'b0, 1'b1, 1);
    n_cmp++; if (r_count !== 9'd119) begin n_fail++; $display("FAIL rec_restore got %0d want 119", r_count); end
    n_cmp++; if ({r_pas, r_ge, r_lt} !== 3'b010) begin n_fail++; $display("FAIL restore_status got %b want 010", {r_pas, r_ge, r_lt}); end
    n_cmp++; if (t_count !== 9'd129) begin n_fail++; $display("FAIL tec_dec_plain got %0d want 129", t_count); end
    do_reset();
    req(1'b0, 1'b0, 1'b1, 1);
    n_cmp++; if (r_count !== 9'd0) begin n_fail++; $display("FAIL dec_at_zero got %0d want 0", r_count); end
    req(1'b1, 1'b0, 1'b1, 1);
    n_cmp++; if (r_count !== 9'd0) begin n_fail++; $display("FAIL dec_zero_blocks_inc got %0d want 0", r_count); end
  endtask

  task automatic test_rec_prio();
    do_reset();
    for (int i = 0; i < 50; i++) req(1'b1, 1'b0, 1'b0, 1);
    req(1'b1, 1'b0, 1'b1, 3);
    n_cmp++; if (r_count !== 9'd49) begin n_fail++; $display("FAIL dec_over_inc got %0d want 49", r_count); end
    req(1'b1, 1'b1, 1'b0, 2);
    n_cmp++; if (r_count !== 9'd50) begin n_fail++; $display("FAIL one_over_big got %0d want 50", r_count); end
    for (int i = 0; i < 25; i++) req(1'b0, 1'b1, 1'b0, 1);
    n_cmp++; if (r_count !== 9'd250) begin n_fail++; $display("FAIL reach_250 got %0d want 250", r_count); end
    req(1'b0, 1'b1, 1'b0, 1);
    n_cmp++; if ({r_count, r_count8} !== {9'd258, 8'd255}) begin n_fail++; $display("FAIL big_to_258 got %0d/%0d want 258/255", r_count, r_count8); end
    n_cmp++; if (r_bo !== 1'b0) begin n_fail++; $display("FAIL rec_never_busoff got %b want 0", r_bo); end
    req(1'b0, 1'b1, 1'b0, 1);
    n_cmp++; if (r_count !== 9'd258) begin n_fail++; $display("FAIL legacy_hold got %0d want 258", r_count); end
  endtask

  task automatic test_tec_busoff();
    do_reset();
    for (int i = 0; i < 31; i++) req(1'b0, 1'b1, 1'b0, 1);
    req(1'b1, 1'b0, 1'b0, 1);
    req(1'b1, 1'b0, 1'b0, 1);
    n_cmp++; if ({t_count, t_bo, t_pas} !== {9'd250, 1'b0, 1'b1}) begin n_fail++; $display("FAIL tec_250 got %0d/%b/%b want 250/0/1", t_count, t_bo, t_pas); end
    req(1'b0, 1'b1, 1'b0, 1);
    n_cmp++; if ({t_count, t_bo, t_ge, t_lt} !== {9'd258, 3'b110}) begin n_fail++; $display("FAIL enter_busoff got %0d/%b%b%b want 258/110", t_count, t_bo, t_ge, t_lt); end
    req(1'b1, 1'b0, 1'b0, 1);
    req(1'b0, 1'b0, 1'b1, 1);
    n_cmp++; if (t_count !== 9'd258) begin n_fail++; $display("FAIL busoff_frozen got %0d want 258", t_count); end
    pulse_rec11(127);
    n_cmp++; if ({t_bo, t_rc, t_done} !== {1'b1, 8'd127, 1'b0}) begin n_fail++; $display("FAIL recov_127 got %b/%0d/%b want 1/127/0", t_bo, t_rc, t_done); end
    rec11 = 1'b1;
    @(negedge clock);
    rec11 = 1'b0;
    n_cmp++; if ({t_count, t_bo, t_done, t_rc} !== {9'd0, 1'b0, 1'b1, 8'd0}) begin n_fail++; $display("FAIL recov_done got %0d/%b/%b/%0d want 0/0/1/0", t_count, t_bo, t_done, t_rc); end
    @(negedge clock);
    n_cmp++; if (t_done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", t_done); end
    n_cmp++; if ({t_lt, t_ge, t_pas} !== 3'b100) begin n_fail++; $display("FAIL post_recov_status got %b want 100", {t_lt, t_ge, t_pas}); end
    pulse_rec11(2);
    n_cmp++; if (t_rc !== 8'd0) begin n_fail++; $display("FAIL rec11_ignored got %0d want 0", t_rc); end
  endtask

  task automatic test_tec_clear();
    do_reset();
    for (int i = 0; i < 32; i++) req(1'b0, 1'b1, 1'b0, 1);
    n_cmp++; if ({t_count, t_bo} !== {9'd256, 1'b1}) begin n_fail++; $display("FAIL busoff_at_256 got %0d/%b want 256/1", t_count, t_bo); end
    pulse_rec11(60);
    n_cmp++; if (t_rc !== 8'd60) begin n_fail++; $display("FAIL recov_60 got %0d want 60", t_rc); end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    n_cmp++; if ({t_count, t_bo, t_rc, t_done} !== {9'd0, 1'b0, 8'd0, 1'b0}) begin n_fail++; $display("FAIL clear_abort got %0d/%b/%0d/%b want 0/0/0/0", t_count, t_bo, t_rc, t_done); end
    @(negedge clock);
    n_cmp++; if (t_done !== 1'b0) begin n_fail++; $display("FAIL clear_no_done got %b want 0", t_done); end
  endtask

  task automatic test_reset_held();
    do_reset();
    inc_one = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (r_count !== 9'd1) begin n_fail++; $display("FAIL held_pre_reset got %0d want 1", r_count); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if ({r_count, r_lt, r_ge, r_pas, r_bo, r_done} !== {9'd0, 5'b10000}) begin n_fail++; $display("FAIL reset_while_held got %0d/%b want 0/10000", r_count, {r_lt, r_ge, r_pas, r_bo, r_done}); end
    inc_one = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (r_count !== 9'd0) begin n_fail++; $display("FAIL after_release got %0d want 0", r_count); end
    req(1'b1, 1'b0, 1'b0, 2);
    n_cmp++; if (r_count !== 9'd1) begin n_fail++; $display("FAIL rise_again got %0d want 1", r_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) req(1'b0, 1'b1, 1'b0, 1);
    n_cmp++; if (r_count !== 9'd32) begin n_fail++; $display("FAIL b2b_big got %0d want 32", r_count); end
    req(1'b0, 1'b0, 1'b1, 1);
    req(1'b0, 1'b0, 1'b1, 1);
    n_cmp++; if (r_count !== 9'd30) begin n_fail++; $display("FAIL b2b_dec got %0d want 30", r_count); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; clear = 1'b0; rec11 = 1'b0;
    inc_one = 1'b0; inc_big = 1'b0; dec_one = 1'b0;
    @(negedge clock);
    test_reset();
    test_rec_warn();
    test_rec_restore();
    test_rec_prio();
    test_tec_busoff();
    test_tec_clear();
    test_reset_held();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
